// File: rtl/nabp_angle_sequencer.sv
// nabp_angle_sequencer
//
// Top-level scheduler for the back-projection shifter. It walks every
// (partition, angle) pair in order. For each pair it pulses the shifter LUT
// load, kicks the shifter fill phase and waits for it to finish. It then waits
// for the downstream PE, kicks the shift phase and waits for that to finish.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          host request to begin a full sweep (honoured in IDLE only)
//   abort          synchronous abort back to IDLE, clears angle/partition
//   busy           high in every state except IDLE
//   done           one-cycle pulse when the sweep completes
//   lut_load       one-cycle pulse: LUT latches sl_accu_base for angle/partition
//   angle          current angle index
//   partition      current partition index
//   sh_fill_kick   one-cycle pulse starting the shifter fill phase
//   sh_fill_done   shifter fill-complete level (sampled in FILL_WAIT only)
//   sh_shift_kick  one-cycle pulse starting the shifter shift phase
//   sh_shift_done  shifter shift-complete level (sampled in SHIFT_WAIT only)
//   pe_ready       downstream PE can accept a shift phase
//
// All outputs are registered from the next-state decode, so no input reaches
// an output without passing through a flop.

module nabp_angle_sequencer #(
    parameter int ANGLE_LEN      = 180,
    parameter int NUM_PARTITIONS = 4,
    parameter int ANGLE_W        = 8,
    parameter int PART_W         = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               lut_load,
    output logic [ANGLE_W-1:0] angle,
    output logic [PART_W-1:0]  partition,
    output logic               sh_fill_kick,
    input  logic               sh_fill_done,
    output logic               sh_shift_kick,
    input  logic               sh_shift_done,
    input  logic               pe_ready
);

    localparam logic [ANGLE_W-1:0] ANGLE_LAST = ANGLE_W'(ANGLE_LEN - 1);
    localparam logic [PART_W-1:0]  PART_LAST  = PART_W'(NUM_PARTITIONS - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LUT_LOAD   = 4'd1,
        LUT_WAIT   = 4'd2,
        FILL_KICK  = 4'd3,
        FILL_WAIT  = 4'd4,
        PE_WAIT    = 4'd5,
        SHIFT_KICK = 4'd6,
        SHIFT_WAIT = 4'd7,
        ADVANCE    = 4'd8,
        DONE       = 4'd9
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ANGLE_W-1:0] angle_nxt;
    logic [PART_W-1:0]  partition_nxt;

    // Next-state and index update. The done inputs are only looked at in the
    // two wait states, which both begin the cycle after their kick, so a done
    // level left high from an earlier phase cannot short-circuit a kick.
    always_comb begin
        state_nxt     = state;
        angle_nxt     = angle;
        partition_nxt = partition;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = LUT_LOAD;
                    angle_nxt     = '0;
                    partition_nxt = '0;
                end
            end
            LUT_LOAD:   state_nxt = LUT_WAIT;
            LUT_WAIT:   state_nxt = FILL_KICK;   // covers the LUT read latency
            FILL_KICK:  state_nxt = FILL_WAIT;
            FILL_WAIT:  if (sh_fill_done)  state_nxt = PE_WAIT;
            PE_WAIT:    if (pe_ready)      state_nxt = SHIFT_KICK;
            SHIFT_KICK: state_nxt = SHIFT_WAIT;
            SHIFT_WAIT: if (sh_shift_done) state_nxt = ADVANCE;
            ADVANCE: begin
                if (angle == ANGLE_LAST && partition == PART_LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = LUT_LOAD;
                    if (angle == ANGLE_LAST) begin
                        angle_nxt     = '0;
                        partition_nxt = partition + PART_W'(1);
                    end else begin
                        angle_nxt = angle + ANGLE_W'(1);
                    end
                end
            end
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;        // illegal encodings recover
        endcase

        // Abort overrides everything, including a simultaneous start in IDLE.
        // In IDLE the final indices of a finished sweep are left untouched.
        if (abort) begin
            state_nxt = IDLE;
            if (state != IDLE) begin
                angle_nxt     = '0;
                partition_nxt = '0;
            end
        end
    end

    // Single state register; outputs are decoded from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            angle         <= '0;
            partition     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lut_load      <= 1'b0;
            sh_fill_kick  <= 1'b0;
            sh_shift_kick <= 1'b0;
        end else begin
            state         <= state_nxt;
            angle         <= angle_nxt;
            partition     <= partition_nxt;
            busy          <= (state_nxt != IDLE);
            done          <= (state_nxt == DONE);
            lut_load      <= (state_nxt == LUT_LOAD);
            sh_fill_kick  <= (state_nxt == FILL_KICK);
            sh_shift_kick <= (state_nxt == SHIFT_KICK);
        end
    end

endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Testbench for nabp_angle_sequencer (ANGLE_LEN=3, NUM_PARTITIONS=2).
// Each cycle begins 1 time unit after the rising edge. Inputs driven then are
// sampled at the next edge, and outputs read then describe the current cycle.

module tb_nabp_angle_sequencer;

    localparam int AL = 3;
    localparam int NP = 2;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       lut_load;
    logic [1:0] angle;
    logic [0:0] partition;
    logic       sh_fill_kick;
    logic       sh_fill_done;
    logic       sh_shift_kick;
    logic       sh_shift_done;
    logic       pe_ready;

    int n_checks = 0;
    int n_err    = 0;
    int last_p   = 0;
    int last_a   = 0;
    int n_lut    = 0;
    int n_fill   = 0;
    int n_shift  = 0;
    int n_done   = 0;

    nabp_angle_sequencer #(
        .ANGLE_LEN      (AL),
        .NUM_PARTITIONS (NP),
        .ANGLE_W        (2),
        .PART_W         (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .lut_load      (lut_load),
        .angle         (angle),
        .partition     (partition),
        .sh_fill_kick  (sh_fill_kick),
        .sh_fill_done  (sh_fill_done),
        .sh_shift_kick (sh_shift_kick),
        .sh_shift_done (sh_shift_done),
        .pe_ready      (pe_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (lut_load)      n_lut++;
        if (sh_fill_kick)  n_fill++;
        if (sh_shift_kick) n_shift++;
        if (done)          n_done++;
    end

    logic [7:0] obs;
    assign obs = {busy, done, lut_load, sh_fill_kick, sh_shift_kick, partition, angle};

    function automatic logic [7:0] ev(input bit b, input bit d, input bit l,
                                      input bit f, input bit s, input int p, input int a);
        logic [7:0] r;
        r = {b, d, l, f, s, p[0], a[1:0]};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b (busy,done,lut,fill,shift,part,angle)",
                   tag, obs, expv);
        end
    endtask

    task automatic chk_val(input string tag, input int got, input int expv);
        n_checks++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs the sequencer must ignore in the current cycle get random values.
    task automatic noise(input bit stale);
        sh_fill_done  = stale ? 1'b1 : 1'($urandom_range(0, 1));
        sh_shift_done = 1'($urandom_range(0, 1));
        pe_ready      = 1'($urandom_range(0, 1));
        start         = 1'($urandom_range(0, 1));
    endtask

    // One (partition, angle) pair, entered on its LUT_LOAD cycle. On return
    // the current cycle is the one following ADVANCE (or the IDLE after abort).
    task automatic run_pair(input int p, input int a, input int fd, input int pst,
                            input int sd, input bit stale, input bit do_abort,
                            output bit aborted);
        aborted = 1'b0;
        noise(stale);
        chk("lut_load", ev(1, 0, 1, 0, 0, p, a));
        tick();
        noise(stale);
        chk("lut_wait", ev(1, 0, 0, 0, 0, p, a));
        tick();
        noise(stale);
        chk("fill_kick", ev(1, 0, 0, 1, 0, p, a));
        for (int i = 1; i <= fd; i++) begin
            tick();
            noise(stale);
            sh_fill_done = stale ? 1'b1 : (i == fd);
            chk("fill_wait", ev(1, 0, 0, 0, 0, p, a));
        end
        for (int j = 0; j <= pst; j++) begin
            tick();
            noise(stale);
            pe_ready = (j == pst);
            chk("pe_wait", ev(1, 0, 0, 0, 0, p, a));
        end
        tick();
        noise(stale);
        chk("shift_kick", ev(1, 0, 0, 0, 1, p, a));
        for (int i = 1; i <= sd; i++) begin
            tick();
            noise(stale);
            if (do_abort) begin
                sh_shift_done = 1'b0;
                start         = 1'b0;
                abort         = 1'b1;
                chk("shift_wait_pre_abort", ev(1, 0, 0, 0, 0, p, a));
                tick();
                abort = 1'b0;
                chk("abort", ev(0, 0, 0, 0, 0, 0, 0));
                aborted = 1'b1;
                return;
            end
            sh_shift_done = (i == sd);
            chk("shift_wait", ev(1, 0, 0, 0, 0, p, a));
        end
        tick();
        noise(stale);
        chk("advance", ev(1, 0, 0, 0, 0, p, a));
        tick();
    endtask

    // mode 0: fixed delays, 1: random delays with latency/backpressure pairs,
    // 2: abort in SHIFT_WAIT of (0,1), 3: fill_done held high throughout.
    task automatic sweep(input int mode);
        int fd, pst, sd;
        bit st, ab, do_ab;
        int pairs[$];
        for (int p = 0; p < NP; p++)
            for (int a = 0; a < AL; a++)
                pairs.push_back(p * 256 + a);
        abort = 1'b0;
        start = 1'b1;
        chk("idle_start", ev(0, 0, 0, 0, 0, last_p, last_a));
        tick();
        while (pairs.size() > 0) begin
            int pa, p, a;
            pa = pairs.pop_front();
            p  = pa / 256;
            a  = pa % 256;
            st = 1'b0;
            do_ab = 1'b0;
            fd  = $urandom_range(1, 6);
            pst = $urandom_range(0, 4);
            sd  = $urandom_range(1, 6);
            case (mode)
                0: begin fd = 4; pst = 0; sd = 5; end
                1: begin
                    if (p == 0 && a == 0) begin fd = 3; pst = 0; end
                    if (p == 0 && a == 1) pst = 20;
                end
                2: do_ab = (p == 0 && a == 1);
                default: begin st = 1'b1; fd = 1; end
            endcase
            run_pair(p, a, fd, pst, sd, st, do_ab, ab);
            if (ab) begin
                tick();
                chk("post_abort_idle", ev(0, 0, 0, 0, 0, 0, 0));
                last_p = 0;
                last_a = 0;
                return;
            end
        end
        start = 1'b0;
        chk("done", ev(1, 1, 0, 0, 0, NP - 1, AL - 1));
        tick();
        chk("idle_after_done", ev(0, 0, 0, 0, 0, NP - 1, AL - 1));
        last_p = NP - 1;
        last_a = AL - 1;
    endtask

    initial begin
        int s_lut, s_fill, s_shift, s_done;
        reset_n       = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        sh_fill_done  = 1'b0;
        sh_shift_done = 1'b0;
        pe_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 8'h00);
        reset_n = 1'b1;
        tick();
        chk("idle", 8'h00);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", 8'h00);
        tick();
        chk("start_abort_hold", 8'h00);

        s_lut = n_lut; s_fill = n_fill; s_shift = n_shift; s_done = n_done;
        sweep(0);
        chk_val("lut_count",   n_lut   - s_lut,   AL * NP);
        chk_val("fill_count",  n_fill  - s_fill,  AL * NP);
        chk_val("shift_count", n_shift - s_shift, AL * NP);
        chk_val("done_count",  n_done  - s_done,  1);

        sweep(1);
        s_done = n_done;
        sweep(2);
        chk_val("abort_no_done", n_done - s_done, 0);
        sweep(0);
        sweep(3);

        // asynchronous reset in the middle of FILL_WAIT
        start = 1'b1;
        tick();
        start         = 1'b0;
        sh_fill_done  = 1'b0;
        sh_shift_done = 1'b0;
        pe_ready      = 1'b1;
        tick();
        tick();
        tick();
        chk("fill_wait_pre_reset", ev(1, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b0;
        #1;
        chk("async_reset", 8'h00);
        tick();
        chk("reset_hold", 8'h00);
        reset_n = 1'b1;
        tick();
        chk("after_reset", 8'h00);
        last_p = 0;
        last_a = 0;
        sweep(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/nabp_angle_sequencer.md
Name: nabp_angle_sequencer

Overview:
- Top-level scheduler for the back-projection shifter.
- Walks every (partition, angle) pair in order and loads the shifter LUT for the current pair.
- For each pair it kicks the shifter's fill phase, then its shift phase, and waits for each phase to complete.
- Gates each shift phase on downstream processing-element readiness, and reports busy and done to the host.

Parameters:
ANGLE_LEN, 180, number of projection angles per partition
NUM_PARTITIONS, 4, number of image partitions
ANGLE_W, 8, width of angle index; must satisfy 2^ANGLE_W >= ANGLE_LEN
PART_W, 2, width of partition index; must satisfy 2^PART_W >= NUM_PARTITIONS

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  host request to begin a full sweep, sampled in IDLE only
abort  in  1  synchronous abort, returns to IDLE next cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the sweep completes
lut_load  out  1  one-cycle pulse: LUT latches sl_accu_base for angle/partition
angle  out  ANGLE_W  current angle index
partition  out  PART_W  current partition index
sh_fill_kick  out  1  one-cycle pulse starting the shifter fill phase
sh_fill_done  in  1  level from shifter, fill complete
sh_shift_kick  out  1  one-cycle pulse starting the shifter shift phase
sh_shift_done  in  1  level from shifter, shift complete
pe_ready  in  1  downstream PE able to accept a shift phase

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state=IDLE.
  - All outputs 0; angle=0, partition=0.
- Outputs are Moore, decoded from registered state and counters. No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: on start=1, clear angle and partition, go to LUT_LOAD.
  - LUT_LOAD: lut_load=1 for one cycle, then LUT_WAIT.
  - LUT_WAIT: one cycle to cover the LUT latency, then FILL_KICK.
  - FILL_KICK: sh_fill_kick=1 for one cycle, then FILL_WAIT.
  - FILL_WAIT: on sh_fill_done=1, go to PE_WAIT.
  - PE_WAIT: on pe_ready=1, go to SHIFT_KICK; otherwise stall indefinitely.
  - SHIFT_KICK: sh_shift_kick=1 for one cycle, then SHIFT_WAIT.
  - SHIFT_WAIT: on sh_shift_done=1, go to ADVANCE.
  - ADVANCE: if angle==ANGLE_LEN-1 and partition==NUM_PARTITIONS-1, go to DONE. Otherwise:
    - if angle==ANGLE_LEN-1: angle<=0 and partition<=partition+1;
    - else angle<=angle+1;
    - then go to LUT_LOAD.
  - DONE: done=1 for one cycle, then IDLE. angle and partition hold their final values until the next start.
- Done inputs are sampled only in FILL_WAIT and SHIFT_WAIT. Both wait states begin the cycle after the kick, so the kick cycle never samples a done input. Stale levels outside these states are ignored.
- Per-pair fixed overhead: 6 cycles. The states LUT_LOAD, LUT_WAIT, FILL_KICK, SHIFT_KICK, ADVANCE, plus a minimum 1 cycle in PE_WAIT.
- angle and partition are stable from LUT_LOAD through ADVANCE of the same pair.
- abort=1 in any non-IDLE state:
  - next state is IDLE, with no kick, lut_load or done pulse that cycle;
  - angle and partition are cleared.
- abort and start asserted together in IDLE: abort wins, and the block stays in IDLE.
- start while busy is ignored.
- Asynchronous reset mid-sweep forces IDLE immediately. The shifter is reset by the same reset_n.
- With ANGLE_LEN=1 and NUM_PARTITIONS=1, exactly one pair is processed and ADVANCE goes straight to DONE.
- Unknown or illegal state encodings return to IDLE.

Test Plan:
- Full sweep: ANGLE_LEN=3, NUM_PARTITIONS=2; fill_done 4 cycles after each fill kick; shift_done 5 cycles after each shift kick; pe_ready=1.
  - Expect 6 lut_load, 6 fill kicks and 6 shift kicks.
  - (partition,angle) sequence is (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - Exactly one done pulse; busy falls the cycle after done.
- Latency: start at cycle 0 -> lut_load at cycle 1, sh_fill_kick at cycle 3. fill_done at cycle 6 -> sh_shift_kick at cycle 8.
- Backpressure: hold pe_ready=0 for 20 cycles after fill_done -> no sh_shift_kick until 1 cycle after pe_ready rises; angle unchanged throughout.
- Stale done: hold sh_fill_done=1 continuously -> each fill kick still precedes any shift kick by at least 2 cycles; no fill kick is skipped.
- Abort: assert abort during SHIFT_WAIT of pair (0,1) -> next cycle busy=0, angle=0, partition=0, no done. A subsequent start restarts at (0,0).
- Reset and contention:
  - reset_n low mid-FILL_WAIT -> all outputs 0 asynchronously.
  - start+abort together in IDLE -> stays IDLE.
  - start pulse while busy -> sweep unaffected.
